// File: rtl/apb_reg_bank_if.sv
// rtl/apb_reg_bank_if.sv - APB bus bundle with master and slave views
interface apb_reg_bank_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - APB register bank with wait states and ID block; optional write lock under APB_REG_LOCK_EN
module apb_reg_bank #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_CYCLES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           pclk,
    input  logic                           rstn,
    apb_reg_bank_if.slave                  bus,
    input  logic [3:0]                     ecorevnum,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic                  r_lock;

    logic [9:0]            w_idx;
    logic                  w_data_hit;
    logic                  w_id_hit;
    logic                  w_lock_hit;
    logic                  w_err;
    logic                  w_commit;
    logic [7:0]            w_id_val;
    logic [DATA_WIDTH-1:0] w_rd_val;
    logic                  w_unused;

    assign w_unused   = ^bus.paddr[1:0];
    assign w_idx      = bus.paddr[11:2];
    assign w_data_hit = (w_idx < 10'(NUM_REGS));
    assign w_id_hit   = (w_idx >= 10'h3F4);
`ifdef APB_REG_LOCK_EN
    assign w_lock_hit = (w_idx == 10'h3C0);
`else
    assign w_lock_hit = 1'b0;
`endif

    // Unmapped, ID-region writes and locked data writes all complete with an error and no update
    assign w_err = !(w_data_hit || w_id_hit || w_lock_hit)
                 || (bus.pwrite && w_id_hit)
                 || (bus.pwrite && w_data_hit && r_lock);

    assign w_commit = (r_state == DONE) && bus.psel && bus.penable && bus.pwrite && !w_err;

    always_comb begin
        w_id_val = 8'h00;
        case (w_idx[3:0])
            4'h4:    w_id_val = 8'h04;
            4'h8:    w_id_val = 8'h19;
            4'h9:    w_id_val = 8'hB8;
            4'hA:    w_id_val = 8'h1B;
            4'hB:    w_id_val = {ecorevnum, 4'h0};
            4'hC:    w_id_val = 8'h0D;
            4'hD:    w_id_val = 8'hF0;
            4'hE:    w_id_val = 8'h05;
            4'hF:    w_id_val = 8'hB1;
            default: w_id_val = 8'h00;
        endcase
    end

    always_comb begin
        w_rd_val = '0;
        if (w_data_hit)
            w_rd_val = r_regs[w_idx[IW-1:0]];
        else if (w_id_hit)
            w_rd_val = DATA_WIDTH'(w_id_val);
        else if (w_lock_hit)
            w_rd_val = DATA_WIDTH'(r_lock);
    end

    assign bus.pready  = (r_state == DONE);
    assign bus.pslverr = (r_state == DONE) && w_err;
    assign bus.prdata  = ((r_state == DONE) && !bus.pwrite) ? w_rd_val : '0;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.psel && !bus.penable) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!bus.psel)
                        r_state <= IDLE;
                    else if (r_cnt == 4'd0)
                        r_state <= DONE;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= RESET_VAL;
            r_lock <= 1'b0;
        end else if (w_commit) begin
            if (w_data_hit) begin
                for (int b = 0; b < NB; b++)
                    if (bus.pstrb[b])
                        r_regs[w_idx[IW-1:0]][b*8 +: 8] <= bus.pwdata[b*8 +: 8];
            end
`ifdef APB_REG_LOCK_EN
            if (w_lock_hit && bus.pstrb[0] && bus.pwdata[0])
                r_lock <= 1'b1;
`endif
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
        assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end
endmodule
